// File: rtl/mem_client_arbiter.sv
// Round-robin arbiter sharing one external memory port between the
// instruction cache (client 0) and the data cache (client 1).
module mem_client_arbiter #(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128,
  parameter int TAG_BITS  = 5,
  parameter int BEATS     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               cli_req_valid,
  output logic [1:0]               cli_req_ready,
  input  logic [1:0]               cli_req_rw,
  input  logic [2*ADDR_BITS-1:0]   cli_req_addr,
  input  logic [2*TAG_BITS-1:0]    cli_req_tag,
  input  logic [1:0]               cli_req_data_valid,
  output logic [1:0]               cli_req_data_ready,
  input  logic [2*DATA_BITS-1:0]   cli_req_data_bits,
  input  logic [2*DATA_BITS/8-1:0] cli_req_data_mask,
  output logic [1:0]               cli_resp_valid,
  output logic [DATA_BITS-1:0]     cli_resp_data,
  output logic [TAG_BITS-1:0]      cli_resp_tag,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_rw,
  output logic [ADDR_BITS-1:0]     mem_req_addr,
  output logic [TAG_BITS-1:0]      mem_req_tag,
  output logic                     mem_req_data_valid,
  input  logic                     mem_req_data_ready,
  output logic [DATA_BITS-1:0]     mem_req_data_bits,
  output logic [DATA_BITS/8-1:0]   mem_req_data_mask,
  input  logic                     mem_resp_valid,
  input  logic [DATA_BITS-1:0]     mem_resp_data,
  input  logic [TAG_BITS-1:0]      mem_resp_tag
);

  localparam int MASK_BITS = DATA_BITS / 8;
  localparam int CNT_BITS  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    RDATA = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic [CNT_BITS-1:0] beat_cnt_q, beat_cnt_d;
  logic                sel;

  // On contention the client that did not win last time gets the port.
  always_comb begin
    if (cli_req_valid == 2'b11) sel = ~last_grant_q;
    else                        sel = cli_req_valid[1];
  end

  always_comb begin
    mem_req_rw        = sel ? cli_req_rw[1] : cli_req_rw[0];
    mem_req_addr      = sel ? cli_req_addr[2*ADDR_BITS-1:ADDR_BITS] : cli_req_addr[ADDR_BITS-1:0];
    mem_req_tag       = sel ? cli_req_tag[2*TAG_BITS-1:TAG_BITS] : cli_req_tag[TAG_BITS-1:0];
    mem_req_data_bits = grant_q ? cli_req_data_bits[2*DATA_BITS-1:DATA_BITS]
                                : cli_req_data_bits[DATA_BITS-1:0];
    mem_req_data_mask = grant_q ? cli_req_data_mask[2*MASK_BITS-1:MASK_BITS]
                                : cli_req_data_mask[MASK_BITS-1:0];
    cli_resp_data     = mem_resp_data;
    cli_resp_tag      = mem_resp_tag;
  end

  // Handshakes are gated by reset so an asynchronous reset silences the port at once.
  always_comb begin
    state_d            = state_q;
    grant_d            = grant_q;
    last_grant_d       = last_grant_q;
    beat_cnt_d         = beat_cnt_q;
    mem_req_valid      = 1'b0;
    cli_req_ready      = 2'b00;
    mem_req_data_valid = 1'b0;
    cli_req_data_ready = 2'b00;
    cli_resp_valid     = 2'b00;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          mem_req_valid = |cli_req_valid;
          cli_req_ready = sel ? {mem_req_ready, 1'b0} : {1'b0, mem_req_ready};
          if (mem_req_valid && mem_req_ready) begin
            grant_d      = sel;
            last_grant_d = sel;
            state_d      = mem_req_rw ? WDATA : RDATA;
          end
        end
        WDATA: begin
          mem_req_data_valid = grant_q ? cli_req_data_valid[1] : cli_req_data_valid[0];
          cli_req_data_ready = grant_q ? {mem_req_data_ready, 1'b0} : {1'b0, mem_req_data_ready};
          if (mem_req_data_valid && mem_req_data_ready) state_d = IDLE;
        end
        RDATA: begin
          cli_resp_valid = grant_q ? {mem_resp_valid, 1'b0} : {1'b0, mem_resp_valid};
          if (mem_resp_valid) begin
            if (beat_cnt_q == LAST_BEAT) begin
              beat_cnt_d = '0;
              state_d    = IDLE;
            end else begin
              beat_cnt_d = beat_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule
